bist_controller: RTL and testbench
==================================

BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter NPAT, default 16: test patterns applied per session (2..255).
REQ-002 Parameter PIPE_LAT, default 2: cycles from lfsr_en high to the matching x_ref/x_dut being valid (1..7).
REQ-003 Parameter ERR_W, default 8: mismatch counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to run a full test; honoured only in IDLE or DONE.
REQ-007 abort  in  1  synchronous abort, any state.
REQ-008 x_ref, x_dut  in  1 each  fault-free and fault-induced CLB outputs to compare.
REQ-009 lfsr_load  out  1  seed the pattern LFSR (one-cycle pulse).
REQ-010 lfsr_en  out  1  advance the LFSR by one pattern.
REQ-011 fault_sel  out  2  00 none, 01 stuck-at-0, 10 stuck-at-1; drives sa0/sa1 of the induced copy.
REQ-012 busy, done, pass, fail  out  1 each  status.
REQ-013 err_cnt  out  ERR_W  mismatches in current/last session.
REQ-014 det_mask  out  3  per-session result bit: [0] none clean, [1] sa0 detected, [2] sa1 detected.

Function
REQ-015 FSM states IDLE, SEED, RUN, DRAIN, EVAL, DONE.
REQ-016 IDLE/DONE + start: go to SEED with fault_sel=00, det_mask cleared, done/pass/fail low.
REQ-017 SEED lasts 1 cycle: lfsr_load=1, err_cnt cleared, pattern counter cleared.
REQ-018 RUN lasts exactly NPAT cycles with lfsr_en=1 every cycle; pattern counter wraps 0..NPAT-1 then exits to DRAIN.
REQ-019 DRAIN lasts exactly PIPE_LAT cycles, lfsr_en=0.
REQ-020 Compare strobe = lfsr_en delayed PIPE_LAT cycles; exactly NPAT strobes per session.
REQ-021 On strobe with x_ref != x_dut, err_cnt increments, saturating at 2^ERR_W-1.
REQ-022 EVAL lasts 1 cycle: det_mask[fault_sel] set to (err_cnt==0) for session 00, (err_cnt!=0) for 01/10.
REQ-023 EVAL with fault_sel 00 or 01: fault_sel increments, next state SEED; with 10: next state DONE.
REQ-024 fault_sel changes only on EVAL->SEED; stable for the whole session.
REQ-025 Entering DONE: done=1, pass=(det_mask==3'b111), fail=~pass; held until start, abort or reset.
REQ-026 busy=1 in SEED, RUN, DRAIN, EVAL; 0 otherwise.
REQ-027 start while busy is ignored.
REQ-028 abort has priority over start and all transitions: next state IDLE, strobe pipeline flushed, all outputs to reset values.
REQ-029 Total test latency from start to done = 3*(NPAT+PIPE_LAT+2)+1 cycles.

Reset
REQ-030 rst low: state IDLE, fault_sel=00, err_cnt=0, det_mask=0, strobe pipeline cleared, every 1-bit output 0, immediately and independent of clk.
REQ-031 rst low mid-session abandons the test; no partial result is reported after release.

Configuration
REQ-032 BIST_SIGNATURE_EN defined: 16-bit MISR (poly x^16+x^12+x^5+1) compacts x_dut on every strobe, cleared in SEED; output sig[15:0] holds the last session's signature from EVAL until next SEED/abort/reset.
REQ-033 BIST_SIGNATURE_EN undefined: no MISR, no sig port; all other behaviour identical.

Verification
REQ-034 NPAT=16, PIPE_LAT=2, x_dut=x_ref in session 00, x_dut=~x_ref in 01/10 -> det_mask=111, pass=1, fail=0, done 61 cycles after start.
REQ-035 x_dut always equal to x_ref -> det_mask=001, fail=1, err_cnt=0.
REQ-036 Single mismatch on strobe 5 of session 00 only, faults detected otherwise -> det_mask=110, fail=1.
REQ-037 Mismatch on every strobe with ERR_W=3, NPAT=16 -> err_cnt saturates at 7, no wrap.
REQ-038 abort during RUN of session 01 -> IDLE next cycle, busy=0, fault_sel=00, done=0; following start completes normally.
REQ-039 rst low mid-DRAIN, start pulsed while busy -> outputs zero asynchronously; busy start ignored, lfsr_load count=3 per full test.

Source files
------------

// File: rtl/bist_controller_if.sv
// Handshake/status bundle between a BIST sequencer and its host/CUT wrapper.
// The sig port exists only when BIST_SIGNATURE_EN is defined.
interface bist_controller_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic             abort;
   logic             x_ref;
   logic             x_dut;
   logic             lfsr_load;
   logic             lfsr_en;
   logic [1:0]       fault_sel;
   logic             busy;
   logic             done;
   logic             pass;
   logic             fail;
   logic [ERR_W-1:0] err_cnt;
   logic [2:0]       det_mask;
`ifdef BIST_SIGNATURE_EN
   logic [15:0]      sig;

   modport slave (
      input  start, abort, x_ref, x_dut,
      output lfsr_load, lfsr_en, fault_sel, busy, done, pass, fail,
             err_cnt, det_mask, sig
   );
   modport master (
      output start, abort, x_ref, x_dut,
      input  lfsr_load, lfsr_en, fault_sel, busy, done, pass, fail,
             err_cnt, det_mask, sig
   );
`else
   modport slave (
      input  start, abort, x_ref, x_dut,
      output lfsr_load, lfsr_en, fault_sel, busy, done, pass, fail,
             err_cnt, det_mask
   );
   modport master (
      output start, abort, x_ref, x_dut,
      input  lfsr_load, lfsr_en, fault_sel, busy, done, pass, fail,
             err_cnt, det_mask
   );
`endif
endinterface

// File: rtl/bist_controller.sv
// Three-session CLB BIST sequencer (fault-free, stuck-at-0, stuck-at-1) with strobed compare.
// Optional 16-bit MISR signature on x_dut enabled by defining BIST_SIGNATURE_EN.
module bist_controller #(
   parameter int NPAT     = 16,
   parameter int PIPE_LAT = 2,
   parameter int ERR_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   bist_controller_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SEED  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_EVAL  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [7:0]       NPAT_LAST  = 8'(NPAT - 1);
   localparam logic [7:0]       DRAIN_LAST = 8'(PIPE_LAT - 1);
   localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_ZERO   = {ERR_W{1'b0}};
   localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

   state_t               state_r;
   logic [7:0]           cnt_r;
   logic [PIPE_LAT-1:0]  strb_pipe_r;
   logic                 lfsr_load_r;
   logic                 lfsr_en_r;
   logic [1:0]           fault_sel_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 pass_r;
   logic                 fail_r;
   logic [ERR_W-1:0]     err_cnt_r;
   logic [2:0]           det_mask_r;

   logic                 strobe_s;
   logic                 mis_s;
   logic                 hit_s;
   logic [2:0]           det_upd_s;

   assign strobe_s = strb_pipe_r[PIPE_LAT-1];
   assign mis_s    = strobe_s & (bus.x_ref ^ bus.x_dut);

   // Session verdict: the clean run must see no errors, the faulted runs must see some.
   always_comb begin
      hit_s     = 1'b0;
      det_upd_s = det_mask_r;
      if (fault_sel_r == 2'b00) begin
         hit_s = (err_cnt_r == ERR_ZERO);
      end else begin
         hit_s = (err_cnt_r != ERR_ZERO);
      end
      case (fault_sel_r)
         2'b00:   det_upd_s[0] = hit_s;
         2'b01:   det_upd_s[1] = hit_s;
         2'b10:   det_upd_s[2] = hit_s;
         default: det_upd_s    = det_mask_r;
      endcase
   end

   // Compare strobe: lfsr_en delayed by the CUT pipeline latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         strb_pipe_r <= {PIPE_LAT{1'b0}};
      end else if (bus.abort) begin
         strb_pipe_r <= {PIPE_LAT{1'b0}};
      end else begin
         strb_pipe_r <= PIPE_LAT'({strb_pipe_r, lfsr_en_r});
      end
   end

   // Session sequencer, mismatch counter and all registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 8'd0;
         lfsr_load_r <= 1'b0;
         lfsr_en_r   <= 1'b0;
         fault_sel_r <= 2'b00;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
         err_cnt_r   <= ERR_ZERO;
         det_mask_r  <= 3'b000;
      end else if (bus.abort) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 8'd0;
         lfsr_load_r <= 1'b0;
         lfsr_en_r   <= 1'b0;
         fault_sel_r <= 2'b00;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
         err_cnt_r   <= ERR_ZERO;
         det_mask_r  <= 3'b000;
      end else begin
         lfsr_load_r <= 1'b0;
         if (mis_s && (err_cnt_r != ERR_MAX)) begin
            err_cnt_r <= err_cnt_r + ERR_ONE;
         end
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_r     <= ST_SEED;
                  cnt_r       <= 8'd0;
                  lfsr_load_r <= 1'b1;
                  fault_sel_r <= 2'b00;
                  busy_r      <= 1'b1;
                  done_r      <= 1'b0;
                  pass_r      <= 1'b0;
                  fail_r      <= 1'b0;
                  err_cnt_r   <= ERR_ZERO;
                  det_mask_r  <= 3'b000;
               end
            end
            ST_SEED: begin
               state_r   <= ST_RUN;
               cnt_r     <= 8'd0;
               lfsr_en_r <= 1'b1;
            end
            ST_RUN: begin
               if (cnt_r == NPAT_LAST) begin
                  state_r   <= ST_DRAIN;
                  cnt_r     <= 8'd0;
                  lfsr_en_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            ST_DRAIN: begin
               if (cnt_r == DRAIN_LAST) begin
                  state_r <= ST_EVAL;
                  cnt_r   <= 8'd0;
               end else begin
                  cnt_r <= cnt_r + 8'd1;
               end
            end
            ST_EVAL: begin
               det_mask_r <= det_upd_s;
               if (fault_sel_r == 2'b10) begin
                  state_r <= ST_DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= (det_upd_s == 3'b111);
                  fail_r  <= (det_upd_s != 3'b111);
               end else begin
                  // The next session starts from a fresh seed and a clean error count.
                  state_r     <= ST_SEED;
                  fault_sel_r <= fault_sel_r + 2'b01;
                  lfsr_load_r <= 1'b1;
                  err_cnt_r   <= ERR_ZERO;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               cnt_r     <= 8'd0;
               lfsr_en_r <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.lfsr_load = lfsr_load_r;
   assign bus.lfsr_en   = lfsr_en_r;
   assign bus.fault_sel = fault_sel_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.fail      = fail_r;
   assign bus.err_cnt   = err_cnt_r;
   assign bus.det_mask  = det_mask_r;

`ifdef BIST_SIGNATURE_EN
   logic [15:0] misr_r;
   logic [15:0] sig_r;

   // One MISR step, polynomial x^16 + x^12 + x^5 + 1.
   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic d);
      logic [15:0] n;
      n = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000);
      return n ^ {15'd0, d};
   endfunction

   // Signature compaction of x_dut on every strobe; snapshot taken in EVAL.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         misr_r <= 16'h0000;
         sig_r  <= 16'h0000;
      end else if (bus.abort) begin
         misr_r <= 16'h0000;
         sig_r  <= 16'h0000;
      end else if (state_r == ST_SEED) begin
         misr_r <= 16'h0000;
         sig_r  <= 16'h0000;
      end else begin
         if (strobe_s) begin
            misr_r <= misr_step(misr_r, bus.x_dut);
         end
         if (state_r == ST_EVAL) begin
            sig_r <= misr_r;
         end
      end
   end

   assign bus.sig = sig_r;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller: CUT model drives x_ref/x_dut, monitor checks results.
module tb_bist_controller;

   localparam int NPAT = 16;
   localparam int PL   = 2;
   localparam int EW   = 3;
   localparam int LAT  = 61;

   logic clk = 1'b0;
   logic rst;

   bist_controller_if #(.ERR_W(EW)) bus ();

   bist_controller #(.NPAT(NPAT), .PIPE_LAT(PL), .ERR_W(EW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef enum int {M_GOOD, M_NODET, M_S5, M_ALLMIS} mode_t;

   typedef struct {
      logic [2:0]    det;
      logic          pass;
      logic          fail;
      logic [EW-1:0] err;
      int            t0;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] seed_q[$];
   mode_t      mode;
   int         n_chk  = 0;
   int         n_fail = 0;
   int         cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // CUT model: x valid PL cycles after lfsr_en; mismatches outside strobes must be ignored.
   logic en_d1 = 1'b0, en_d2 = 1'b0, strb, mis, r;
   int   sidx = 0;
   always @(negedge clk) begin
      strb  = en_d2;
      en_d2 = en_d1;
      en_d1 = bus.lfsr_en;
      if (bus.lfsr_load) sidx = 0;
      if (strb) sidx++;
      case (mode)
         M_GOOD:   mis = (bus.fault_sel != 2'b00);
         M_NODET:  mis = 1'b0;
         M_S5:     mis = (bus.fault_sel != 2'b00) || (sidx == 5);
         default:  mis = 1'b1;
      endcase
      r         = 1'($urandom);
      bus.x_ref = r;
      bus.x_dut = strb ? (r ^ mis) : ~r;
   end

   // Monitor: pops expected fault_sel on each seed and the expected verdict on done rising.
   logic done_q = 1'b0;
   always @(negedge clk) begin
      exp_t       e;
      logic [1:0] s;
      if (rst) begin
         if (bus.lfsr_load) begin
            if (seed_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL seed_unexpected: got lfsr_load fault_sel=%0d expected no seed", bus.fault_sel);
            end else begin
               s = seed_q.pop_front();
               chk("seed_fault_sel", 32'(bus.fault_sel), 32'(s));
               chk("seed_busy", 32'(bus.busy), 32'd1);
            end
         end
         if (bus.done && !done_q) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL done_unexpected: got done=1 expected no result");
            end else begin
               e = exp_q.pop_front();
               chk("done_det_mask", 32'(bus.det_mask), 32'(e.det));
               chk("done_pass",     32'(bus.pass),     32'(e.pass));
               chk("done_fail",     32'(bus.fail),     32'(e.fail));
               chk("done_err_cnt",  32'(bus.err_cnt),  32'(e.err));
               chk("done_busy",     32'(bus.busy),     32'd0);
               chk("done_latency",  32'(cyc - e.t0),   32'(LAT));
            end
         end
      end
      done_q = bus.done;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic run_start(input mode_t m, input int nseed, input logic full,
                            input logic [2:0] det, input logic p, input logic f,
                            input logic [EW-1:0] err);
      exp_t e;
      mode = m;
      for (int i = 0; i < nseed; i++) seed_q.push_back(2'(i));
      if (full) begin
         e.det = det; e.pass = p; e.fail = f; e.err = err; e.t0 = cyc;
         exp_q.push_back(e);
      end
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!bus.done && k < budget) begin
         tick(1);
         k++;
      end
      if (!bus.done) begin
         n_chk++; n_fail++;
         $display("FAIL done_timeout: got done=0 after %0d cycles expected done=1", budget);
      end
   endtask

   initial begin
      int k;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      mode      = M_GOOD;
      #3;
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_done",      32'(bus.done),      32'd0);
      chk("rst_pass_fail", 32'({bus.pass, bus.fail}), 32'd0);
      chk("rst_lfsr",      32'({bus.lfsr_load, bus.lfsr_en}), 32'd0);
      chk("rst_fault_sel", 32'(bus.fault_sel), 32'd0);
      chk("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
      chk("rst_det_mask",  32'(bus.det_mask),  32'd0);
      tick(2);
      rst = 1'b1;
      tick(2);

      // All faults detected, clean session clean: pass.
      run_start(M_GOOD, 3, 1'b1, 3'b111, 1'b1, 1'b0, 3'd7);
      wait_done(200);
      tick(3);
      chk("done_held", 32'({bus.done, bus.pass, bus.busy}), 32'b110);

      // Faults never observed: only the clean bit set.
      run_start(M_NODET, 3, 1'b1, 3'b001, 1'b0, 1'b1, 3'd0);
      wait_done(200);

      // Single mismatch on strobe 5 of the clean session.
      run_start(M_S5, 3, 1'b1, 3'b110, 1'b0, 1'b1, 3'd7);
      wait_done(200);

      // Mismatch on every strobe: 16 errors saturate at 7 instead of wrapping to 0.
      run_start(M_ALLMIS, 3, 1'b1, 3'b110, 1'b0, 1'b1, 3'd7);
      wait_done(200);

      // Abort during RUN of the stuck-at-0 session, with a competing start.
      run_start(M_GOOD, 2, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
      k = 0;
      while (!(bus.fault_sel == 2'b01 && bus.lfsr_en) && k < 200) begin
         tick(1);
         k++;
      end
      chk("abort_reached_s01_run", 32'({bus.fault_sel, bus.lfsr_en}), 32'b011);
      tick(3);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      tick(1);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      chk("abort_busy",      32'(bus.busy),      32'd0);
      chk("abort_fault_sel", 32'(bus.fault_sel), 32'd0);
      chk("abort_done",      32'(bus.done),      32'd0);
      chk("abort_lfsr_en",   32'(bus.lfsr_en),   32'd0);
      chk("abort_err_cnt",   32'(bus.err_cnt),   32'd0);
      tick(4);
      chk("abort_flushed_err", 32'(bus.err_cnt), 32'd0);
      chk("abort_idle_busy",   32'(bus.busy),    32'd0);
      run_start(M_GOOD, 3, 1'b1, 3'b111, 1'b1, 1'b0, 3'd7);
      wait_done(200);

      // Start while busy is ignored; reset mid-DRAIN clears outputs without a clock.
      run_start(M_GOOD, 1, 1'b0, 3'b000, 1'b0, 1'b0, 3'd0);
      tick(3);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      k = 0;
      while (bus.lfsr_en && k < 200) begin
         tick(1);
         k++;
      end
      chk("drain_reached", 32'({bus.busy, bus.lfsr_en}), 32'b10);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_async_outs", 32'({bus.busy, bus.done, bus.pass, bus.fail, bus.lfsr_load,
                                 bus.lfsr_en, bus.fault_sel, bus.err_cnt, bus.det_mask}), 32'd0);
      tick(2);
      rst = 1'b1;
      tick(6);
      chk("post_rst_status", 32'({bus.busy, bus.done, bus.pass, bus.fail, bus.det_mask}), 32'd0);
      run_start(M_GOOD, 3, 1'b1, 3'b111, 1'b1, 1'b0, 3'd7);
      wait_done(200);
      tick(2);

      chk("seed_q_empty", 32'(seed_q.size()), 32'd0);
      chk("exp_q_empty",  32'(exp_q.size()),  32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
